wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Register file for the pipelined CPU. It sits directly downstream of the memory/writeback stage and consumes that stage's final write data together with the register-write enable.
- Provides two combinational read ports to decode, with same-cycle write-through bypass and a hardwired zero register.
- Contains a load-use scoreboard. It tracks registers with an LW in flight and raises a stall request for decode.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of architectural registers (must equal 2**ADDR_W)

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- wb_wrenable  input  1  writeback register-write enable, from the writeback stage's reg_wrenable
- wb_addr  input  ADDR_W  writeback destination register
- wb_data  input  DATA_W  writeback value (ALU result, load data, or pc+1 on jump)
- rs_addr  input  ADDR_W  read port A index
- rt_addr  input  ADDR_W  read port B index
- rs_used  input  1  decode instruction actually reads rs
- rt_used  input  1  decode instruction actually reads rt
- rs_data  output  DATA_W  read port A value
- rt_data  output  DATA_W  read port B value
- issue_valid  input  1  an instruction leaves decode this cycle
- issue_is_load  input  1  the issuing instruction is LW
- issue_dest  input  ADDR_W  the issuing instruction's destination register
- load_stall  output  1  decode must hold; an operand is awaiting load data

Behaviour:
- Reset (rst_n low, asynchronous):
  - All NUM_REGS registers clear to 0 and all busy bits clear to 0.
  - rs_data/rt_data then read 0 and load_stall reads 0.
  - Reset asserted mid-operation discards all pending scoreboard state immediately.
- Write: on posedge clk, if wb_wrenable and wb_addr != 0, then regs[wb_addr] <= wb_data. Writes to r0 are ignored.
- Read (combinational, zero latency), evaluated per port in this priority:
  - index == 0 -> 0;
  - else wb_wrenable and wb_addr == index -> wb_data (write-through bypass);
  - else regs[index].
- Scoreboard: one busy bit per register; busy[0] is constant 0.
  - Set on posedge clk when issue_valid && issue_is_load && issue_dest != 0.
  - Cleared on posedge clk when wb_wrenable && wb_addr == that register.
  - Same register set and cleared in the same cycle: set wins. The newer load is still outstanding.
- load_stall, combinational:
  - rs_term = rs_used && busy[rs_addr] && !(wb_wrenable && wb_addr == rs_addr)
  - rt_term = rt_used && busy[rt_addr] && !(wb_wrenable && wb_addr == rt_addr)
  - load_stall = rs_term || rt_term
  - A writeback landing in the stalled cycle releases the stall that same cycle, because the bypass supplies the data.
- While load_stall is high, upstream holds issue_valid low. Any issue_valid seen while load_stall is high is a protocol error; assert it in simulation.
- No flush input. Jumps resolve before issue, so every issued load reaches writeback exactly once.
- The writeback enable for an LW is the writeback stage's reg_wrenable. Non-load writebacks to a busy register also clear busy; a compiler never schedules such a WAW while a load is outstanding.

Optional Feature:
- Macro REGFILE_DEBUG_PORT_EN.
- When defined, adds ports dbg_addr (input, ADDR_W) and dbg_data (output, DATA_W). dbg_data is a third combinational read port with the same zero/bypass rules; it is used for the board's display.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds DATA_W, ADDR_W, NUM_REGS, a ZERO_REG constant (0), and the reg_addr_t/word_t typedefs.
- One natural sub-module, load_scoreboard: busy vector, set/clear logic, and load_stall generation.
- Storage and read/bypass muxes stay in wb_regfile.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst_n low mid-cycle -> rs_data for r5 reads 0 immediately, and load_stall = 0.
- Write then read, and r0: write r3 = 0x12345678; next cycle rs_addr=3 -> 0x12345678. Write r0 = 0xFFFFFFFF -> rs_addr=0 still reads 0.
- Bypass: wb_wrenable=1, wb_addr=7, wb_data=0xA5A5A5A5 with rt_addr=7 in the same cycle -> rt_data = 0xA5A5A5A5 before the clock edge.
- Load-use: issue LW to r9; next cycle rs_addr=9, rs_used=1 -> load_stall=1. Hold until wb_wrenable, wb_addr=9 -> load_stall=0 in that cycle, rs_data = wb_data.
- Unused operand: r9 busy, rt_addr=9, rt_used=0 -> load_stall=0.
- Set/clear collision: r4 busy and its writeback arrives while a new LW to r4 issues -> busy[4] remains 1 the next cycle, and rs_addr=4 with rs_used=1 stalls.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared widths, register-index types and the zero register.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/wb_regfile_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_regfile_if: writeback, read-port and issue signals of wb_regfile. |
// | Debug read port present when REGFILE_DEBUG_PORT_EN is defined.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface wb_regfile_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);
    logic              wb_wrenable;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_used;
    logic              rt_used;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              issue_valid;
    logic              issue_is_load;
    logic [ADDR_W-1:0] issue_dest;
    logic              load_stall;
`ifdef REGFILE_DEBUG_PORT_EN
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
`endif

    modport master (
        output wb_wrenable, wb_addr, wb_data,
        output rs_addr, rt_addr, rs_used, rt_used,
        output issue_valid, issue_is_load, issue_dest,
`ifdef REGFILE_DEBUG_PORT_EN
        output dbg_addr,
        input  dbg_data,
`endif
        input  rs_data, rt_data, load_stall
    );

    modport slave (
        input  wb_wrenable, wb_addr, wb_data,
        input  rs_addr, rt_addr, rs_used, rt_used,
        input  issue_valid, issue_is_load, issue_dest,
`ifdef REGFILE_DEBUG_PORT_EN
        input  dbg_addr,
        output dbg_data,
`endif
        output rs_data, rt_data, load_stall
    );

endinterface
`default_nettype wire

// File: rtl/load_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_scoreboard: per-register busy bits for in-flight loads and the  |
// | decode stall request. Rev 1.0                                        |
// +----------------------------------------------------------------------+
module load_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              issue_valid,
    input  wire logic              issue_is_load,
    input  wire logic [ADDR_W-1:0] issue_dest,
    input  wire logic              wb_wrenable,
    input  wire logic [ADDR_W-1:0] wb_addr,
    input  wire logic [ADDR_W-1:0] rs_addr,
    input  wire logic [ADDR_W-1:0] rt_addr,
    input  wire logic              rs_used,
    input  wire logic              rt_used,
    output logic                   load_stall
);

    logic [NUM_REGS-1:0] r_busy;
    logic                w_rs_term;
    logic                w_rt_term;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
        if (gi == ZERO_REG) begin : g_zero
            assign r_busy[gi] = 1'b0;
        end else begin : g_reg
            logic w_set;
            logic w_clr;
            assign w_set = issue_valid && issue_is_load && (issue_dest == ADDR_W'(gi));
            assign w_clr = wb_wrenable && (wb_addr == ADDR_W'(gi));

            // Set has priority: a re-issued load to the same register stays outstanding.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     r_busy[gi] <= 1'b0;
                else if (w_set) r_busy[gi] <= 1'b1;
                else if (w_clr) r_busy[gi] <= 1'b0;
            end
        end
    end

    // A writeback landing this cycle is forwarded by the bypass, so it releases the stall.
    assign w_rs_term  = rs_used && r_busy[rs_addr] && !(wb_wrenable && wb_addr == rs_addr);
    assign w_rt_term  = rt_used && r_busy[rt_addr] && !(wb_wrenable && wb_addr == rt_addr);
    assign load_stall = w_rs_term || w_rt_term;

    a_no_issue_while_stalled: assert property (
        @(posedge clk) disable iff (!rst_n) !(issue_valid && load_stall)
    );

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_regfile: register file with write-through bypass, r0 hardwired to |
// | zero and a load-use scoreboard. Optional debug read port under       |
// | REGFILE_DEBUG_PORT_EN. Rev 1.0                                       |
// +----------------------------------------------------------------------+
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    wb_regfile_if.slave bus
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] idx,
        input logic              wen,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (idx == ADDR_W'(ZERO_REG))   return '0;
        else if (wen && waddr == idx)   return wdata;
        else                            return stored;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (bus.wb_wrenable && bus.wb_addr != ADDR_W'(ZERO_REG)) begin
            r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign bus.rs_data = read_port(bus.rs_addr, bus.wb_wrenable, bus.wb_addr,
                                   bus.wb_data, r_regs[bus.rs_addr]);
    assign bus.rt_data = read_port(bus.rt_addr, bus.wb_wrenable, bus.wb_addr,
                                   bus.wb_data, r_regs[bus.rt_addr]);

`ifdef REGFILE_DEBUG_PORT_EN
    assign bus.dbg_data = read_port(bus.dbg_addr, bus.wb_wrenable, bus.wb_addr,
                                    bus.wb_data, r_regs[bus.dbg_addr]);
`endif

    load_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_load_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (bus.issue_valid),
        .issue_is_load (bus.issue_is_load),
        .issue_dest    (bus.issue_dest),
        .wb_wrenable   (bus.wb_wrenable),
        .wb_addr       (bus.wb_addr),
        .rs_addr       (bus.rs_addr),
        .rt_addr       (bus.rt_addr),
        .rs_used       (bus.rs_used),
        .rt_used       (bus.rt_used),
        .load_stall    (bus.load_stall)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_regfile: directed and randomized checks of wb_regfile against  |
// | a register/busy array model. Rev 1.0                                 |
// +----------------------------------------------------------------------+
module tb_wb_regfile;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    word_t m_regs [NUM_REGS];
    bit    m_busy [NUM_REGS];

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t exp_read(input reg_addr_t idx);
        if (idx == 0) return '0;
        if (bus.wb_wrenable && bus.wb_addr == idx) return bus.wb_data;
        return m_regs[idx];
    endfunction

    function automatic logic exp_stall();
        logic a, b;
        a = bus.rs_used && m_busy[bus.rs_addr] && !(bus.wb_wrenable && bus.wb_addr == bus.rs_addr);
        b = bus.rt_used && m_busy[bus.rt_addr] && !(bus.wb_wrenable && bus.wb_addr == bus.rt_addr);
        return a || b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        bus.wb_wrenable   = 1'b0;
        bus.wb_addr       = '0;
        bus.wb_data       = '0;
        bus.rs_addr       = '0;
        bus.rt_addr       = '0;
        bus.rs_used       = 1'b0;
        bus.rt_used       = 1'b0;
        bus.issue_valid   = 1'b0;
        bus.issue_is_load = 1'b0;
        bus.issue_dest    = '0;
`ifdef REGFILE_DEBUG_PORT_EN
        bus.dbg_addr      = '0;
`endif
    endtask

    // Advance one clock; the model applies the architectural effect of the inputs held across the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (bus.wb_wrenable && bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
            if (bus.wb_wrenable) m_busy[bus.wb_addr] = 1'b0;
            if (bus.issue_valid && bus.issue_is_load && bus.issue_dest != 0)
                m_busy[bus.issue_dest] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        // Power-on reset values
        rst_n = 1'b0;
        idle();
        model_reset();
        bus.rs_addr = 5'd5;
        bus.rt_addr = 5'd31;
        #1;
        checks++; if (bus.rs_data !== 32'h0) begin errors++; $display("FAIL por_rs: got %h expected %h", bus.rs_data, 32'h0); end
        checks++; if (bus.rt_data !== 32'h0) begin errors++; $display("FAIL por_rt: got %h expected %h", bus.rt_data, 32'h0); end
        checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL por_stall: got %b expected 0", bus.load_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        // Populate state, then reset mid-cycle
        bus.wb_wrenable = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
        bus.issue_valid = 1'b1; bus.issue_is_load = 1'b1; bus.issue_dest = 5'd9;
        tick();
        idle();
        bus.rs_addr = 5'd5;
        bus.rt_addr = 5'd9; bus.rt_used = 1'b1;
        #1;
        checks++; if (bus.rs_data !== exp_read(5'd5)) begin errors++; $display("FAIL pre_rst_rs: got %h expected %h", bus.rs_data, exp_read(5'd5)); end
        checks++; if (bus.load_stall !== exp_stall()) begin errors++; $display("FAIL pre_rst_stall: got %b expected %b", bus.load_stall, exp_stall()); end
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.rs_data !== 32'h0) begin errors++; $display("FAIL mid_rst_rs: got %h expected %h", bus.rs_data, 32'h0); end
        checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall: got %b expected 0", bus.load_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL post_rst_stall: got %b expected 0", bus.load_stall); end
    endtask

    task automatic test_write_read();
        idle();
        bus.wb_wrenable = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h12345678;
        tick();
        idle();
        bus.rs_addr = 5'd3;
        #1;
        checks++; if (bus.rs_data !== 32'h12345678) begin errors++; $display("FAIL rd_r3: got %h expected %h", bus.rs_data, 32'h12345678); end
        bus.wb_wrenable = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFFFFFF;
        bus.rs_addr = 5'd0;
        #1;
        checks++; if (bus.rs_data !== 32'h0) begin errors++; $display("FAIL r0_bypass: got %h expected %h", bus.rs_data, 32'h0); end
        tick();
        idle();
        bus.rs_addr = 5'd0;
        #1;
        checks++; if (bus.rs_data !== 32'h0) begin errors++; $display("FAIL r0_store: got %h expected %h", bus.rs_data, 32'h0); end
    endtask

    task automatic test_bypass();
        idle();
        bus.wb_wrenable = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'hA5A5A5A5;
        bus.rt_addr = 5'd7;
        bus.rs_addr = 5'd3;
        #1;
        checks++; if (bus.rt_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_rt: got %h expected %h", bus.rt_data, 32'hA5A5A5A5); end
        checks++; if (bus.rs_data !== 32'h12345678) begin errors++; $display("FAIL bypass_rs_other: got %h expected %h", bus.rs_data, 32'h12345678); end
        tick();
        idle();
    endtask

    task automatic test_load_use();
        idle();
        bus.issue_valid = 1'b1; bus.issue_is_load = 1'b1; bus.issue_dest = 5'd9;
        tick();
        idle();
        bus.rs_addr = 5'd9; bus.rs_used = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.load_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_%0d: got %b expected 1", i, bus.load_stall); end
            tick();
        end
        bus.wb_wrenable = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hCAFEF00D;
        #1;
        checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", bus.load_stall); end
        checks++; if (bus.rs_data !== 32'hCAFEF00D) begin errors++; $display("FAIL lu_data: got %h expected %h", bus.rs_data, 32'hCAFEF00D); end
        tick();
        idle();
        bus.rs_addr = 5'd9; bus.rs_used = 1'b1;
        #1;
        checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL lu_cleared: got %b expected 0", bus.load_stall); end
    endtask

    task automatic test_unused_operand();
        idle();
        bus.issue_valid = 1'b1; bus.issue_is_load = 1'b1; bus.issue_dest = 5'd9;
        tick();
        idle();
        bus.rt_addr = 5'd9; bus.rt_used = 1'b0;
        #1;
        checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL unused_rt: got %b expected 0", bus.load_stall); end
        bus.rt_used = 1'b1;
        #1;
        checks++; if (bus.load_stall !== 1'b1) begin errors++; $display("FAIL used_rt: got %b expected 1", bus.load_stall); end
        idle();
        bus.wb_wrenable = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h00000909;
        tick();
        idle();
    endtask

    task automatic test_collision();
        idle();
        bus.issue_valid = 1'b1; bus.issue_is_load = 1'b1; bus.issue_dest = 5'd4;
        tick();
        idle();
        bus.wb_wrenable = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h44444444;
        bus.issue_valid = 1'b1; bus.issue_is_load = 1'b1; bus.issue_dest = 5'd4;
        tick();
        idle();
        bus.rs_addr = 5'd4; bus.rs_used = 1'b1;
        #1;
        checks++; if (bus.load_stall !== 1'b1) begin errors++; $display("FAIL collide_stall: got %b expected 1", bus.load_stall); end
        checks++; if (bus.rs_data !== 32'h44444444) begin errors++; $display("FAIL collide_data: got %h expected %h", bus.rs_data, 32'h44444444); end
        bus.rs_used = 1'b0;
        bus.wb_wrenable = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h44440002;
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.wb_wrenable = ($urandom_range(0, 2) != 0);
            bus.wb_addr     = reg_addr_t'($urandom_range(0, 7));
            bus.wb_data     = word_t'($urandom);
            bus.rs_addr     = reg_addr_t'($urandom_range(0, 7));
            bus.rt_addr     = reg_addr_t'($urandom_range(0, 7));
            bus.rs_used     = ($urandom_range(0, 3) != 0);
            bus.rt_used     = ($urandom_range(0, 3) != 0);
            if (!exp_stall()) begin
                bus.issue_valid   = ($urandom_range(0, 1) != 0);
                bus.issue_is_load = ($urandom_range(0, 1) != 0);
                bus.issue_dest    = reg_addr_t'($urandom_range(0, 7));
            end
`ifdef REGFILE_DEBUG_PORT_EN
            bus.dbg_addr = reg_addr_t'($urandom_range(0, 7));
`endif
            #1;
            checks++; if (bus.rs_data !== exp_read(bus.rs_addr)) begin errors++; $display("FAIL rand_rs[%0d]: got %h expected %h", n, bus.rs_data, exp_read(bus.rs_addr)); end
            checks++; if (bus.rt_data !== exp_read(bus.rt_addr)) begin errors++; $display("FAIL rand_rt[%0d]: got %h expected %h", n, bus.rt_data, exp_read(bus.rt_addr)); end
            checks++; if (bus.load_stall !== exp_stall()) begin errors++; $display("FAIL rand_stall[%0d]: got %b expected %b", n, bus.load_stall, exp_stall()); end
`ifdef REGFILE_DEBUG_PORT_EN
            checks++; if (bus.dbg_data !== exp_read(bus.dbg_addr)) begin errors++; $display("FAIL rand_dbg[%0d]: got %h expected %h", n, bus.dbg_data, exp_read(bus.dbg_addr)); end
`endif
            tick();
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_load_use();
        test_unused_operand();
        test_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
